// File: rtl/fib_bcd_converter_if.sv
// Handshake bundle between the BCD converter and its producer/consumer.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the term side, out_valid/out_ready on the result side.
// Optional: FIB_BCD_BLANK_EN adds the out_blank leading-zero mask.
// IN_WIDTH/DIGITS must match the converter instance that uses this bundle.
interface fib_bcd_converter_if #(
    parameter int IN_WIDTH = 16,
    parameter int DIGITS   = 5
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [IN_WIDTH-1:0]   in_value;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_ovf;
`ifdef FIB_BCD_BLANK_EN
    logic [DIGITS-1:0]     out_blank;

    modport master (
        output in_valid, in_value, out_ready,
        input  in_ready, out_valid, out_bcd, out_ovf, out_blank
    );

    modport slave (
        input  in_valid, in_value, out_ready,
        output in_ready, out_valid, out_bcd, out_ovf, out_blank
    );
`else
    modport master (
        output in_valid, in_value, out_ready,
        input  in_ready, out_valid, out_bcd, out_ovf
    );

    modport slave (
        input  in_valid, in_value, out_ready,
        output in_ready, out_valid, out_bcd, out_ovf
    );
`endif
endinterface

// File: rtl/fib_bcd_converter.sv
// Binary term to packed BCD using sequential double-dabble, one input bit per cycle.
// Latency: result valid IN_WIDTH cycles after the accept edge; one term per IN_WIDTH+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Optional: define FIB_BCD_BLANK_EN to add the out_blank leading-zero mask.
module fib_bcd_converter #(
    parameter int IN_WIDTH = 16,
    parameter int DIGITS   = 5
) (
    input  logic               clk,
    input  logic               rst,
    fib_bcd_converter_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IN_WIDTH-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [BCD_W-1:0]    out_bcd_q, out_bcd_d;
    logic                out_ovf_q, out_ovf_d;

    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_shift;
    logic [IN_WIDTH-1:0] bin_shift;
    logic                shift_carry;
    logic                last_shift;

    assign last_shift = (state_q == ST_SHIFT) && (cnt_q == '0);

    // One double-dabble step: +3 on every digit >=5 (pre-shift values), then shift {bcd,bin} left.
    // The bit leaving the top digit is a whole 10^DIGITS, so dropping it leaves value mod 10^DIGITS.
    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
        {shift_carry, bcd_shift, bin_shift} = {bcd_adj, bin_q, 1'b0};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, IN_WIDTH shifts, hold result until the consumer takes it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.in_valid)  state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == '0)   state_d = ST_DONE;
            ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state: load on accept, step while shifting, capture the result on the last step
    always_comb begin
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_bcd_d = out_bcd_q;
        out_ovf_d = out_ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    bin_d = bus.in_value;
                    bcd_d = '0;
                    ovf_d = 1'b0;
                    cnt_d = CNT_LOAD;
                end
            end
            ST_SHIFT: begin
                bin_d = bin_shift;
                bcd_d = bcd_shift;
                ovf_d = ovf_q | shift_carry;
                if (cnt_q == '0) begin
                    out_bcd_d = bcd_shift;
                    out_ovf_d = ovf_q | shift_carry;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any conversion in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_bcd_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            out_bcd_q <= out_bcd_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    // Outputs: handshake flags decode the state, result comes straight from its registers
    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
        bus.out_bcd   = out_bcd_q;
        bus.out_ovf   = out_ovf_q;
    end

`ifdef FIB_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_calc;
    logic [DIGITS-1:0] out_blank_q, out_blank_d;
    logic              blank_run;

    // Leading-zero mask of the final digits; digit 0 is never blanked so zero shows as "0"
    always_comb begin
        blank_calc = '0;
        blank_run  = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            blank_run     = blank_run & (bcd_shift[4*d +: 4] == 4'd0);
            blank_calc[d] = blank_run;
        end
        out_blank_d = last_shift ? blank_calc : out_blank_q;
    end

    // Mask register, captured together with out_bcd
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_blank_q <= '0;
        end else begin
            out_blank_q <= out_blank_d;
        end
    end

    assign bus.out_blank = out_blank_q;
`endif

endmodule

// File: doc/fib_bcd_converter.md
Name: fib_bcd_converter

Overview:
Downstream of the Fibonacci sequence generator. Captures an unsigned binary term and converts it to packed BCD using a sequential double-dabble algorithm (one bit per cycle). Results go to the display/report stage over a valid/ready handshake. This frees the generator from any decimal formatting logic.

Parameters:
IN_WIDTH, 16, width of the binary input term; must match the generator's COUNTER_WIDTH.
DIGITS, 5, number of BCD digits produced; 5 covers 16-bit values (max 65535).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  in_value holds a term to convert.
in_ready  output  1  block can accept a term; high only in IDLE.
in_value  input  IN_WIDTH  unsigned binary term.
out_valid  output  1  out_bcd/out_ovf are valid.
out_ready  input  1  consumer accepts the result.
out_bcd  output  4*DIGITS  packed BCD; digit 0 in bits [3:0], most significant digit on top.
out_ovf  output  1  value did not fit in DIGITS digits.

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; out_bcd=0; out_ovf=0; internal shift register and counter cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch in_value into the binary shift register, clear the BCD accumulator and the overflow flag, load the bit counter with IN_WIDTH-1, go to SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Each cycle: every BCD digit >=5 gets +3 (all digits in parallel, from pre-shift values). Then the {bcd, bin} register shifts left by 1.
  - Any 1 shifted out of the top BCD digit sets the sticky overflow flag.
  - When the counter reaches 0 and that cycle's shift completes: load out_bcd/out_ovf, go to DONE. Otherwise decrement the counter.
  - Exactly IN_WIDTH shift cycles.
- DONE:
  - out_valid=1; out_bcd/out_ovf held stable until the handshake.
  - On an edge with out_ready=1: go to IDLE. out_valid drops; out_bcd/out_ovf keep their last values.
  - in_ready=0 in DONE, so a new accept cannot coincide with output handshake completion.
- Latency: term accepted at edge N gives out_valid=1 starting after edge N+IN_WIDTH.
- Throughput: one term per IN_WIDTH+2 cycles with out_ready held high.
- in_value is sampled only on the accept edge; later changes are ignored.
- Overflow:
  - out_bcd equals the value mod 10^DIGITS.
  - out_ovf=1 iff the value >= 10^DIGITS.
- Zero input: out_bcd=0, out_ovf=0, same latency.
- out_ready asserted outside DONE: ignored.
- rst asserted mid-SHIFT or in DONE: conversion aborted immediately; all outputs return to reset values; no partial result is ever presented.

Optional Feature:
FIB_BCD_BLANK_EN:
- Defined: adds output out_blank [DIGITS-1:0], registered with out_bcd. Bit i=1 iff digit i and all higher digits are zero. Bit 0 is always 0, so value 0 displays a single "0". Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. in_value=0 accepted at edge N -> out_valid after edge N+16; out_bcd=0x00000; out_ovf=0; with BLANK_EN, out_blank=5'b11110.
2. in_value=65535 -> out_bcd=0x65535, out_ovf=0. Hold out_ready=0 for 10 cycles -> out_valid and out_bcd stable, in_ready=0 throughout. Raise out_ready -> IDLE next edge, in_ready=1.
3. Stream Fibonacci terms 1,2,3,5,8,...,46368 with in_valid=1 and out_ready=1 -> each out_bcd is the decimal of its input (e.g. 28657 -> 0x28657). Spacing is exactly 18 cycles between accepts.
4. DIGITS=4, in_value=12345 -> out_bcd=0x2345, out_ovf=1. Next term 9999 -> out_bcd=0x9999, out_ovf=0 (flag not carried over).
5. Accept 4181, assert rst for 1 cycle at shift cycle 7 -> out_valid never rises; outputs reset; in_ready=1 after release. Then 4181 re-sent -> out_bcd=0x04181.
6. Toggle in_value every cycle during SHIFT after accepting 610 -> out_bcd=0x00610; changes ignored.
